// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the two-read / one-write register file.
// The byte-merge helper is used by both the storage write path and the read bypass.
package reg_file_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    // Widest word the shared helpers handle; callers zero-extend into it and truncate back.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    typedef logic [MAX_DATA_W-1:0] word_max_t;
    typedef logic [MAX_BYTES-1:0]  be_max_t;

    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic word_max_t byte_merge(
        input word_max_t old_w,
        input word_max_t new_w,
        input be_max_t   be
    );
        word_max_t res;
        res = old_w;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: entry select, range check, optional write bypass,
// and the per-port out-of-range flag that the top folds into addr_err_o.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = calc_addr_w(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_W-1:0]     mem_i [DEPTH],
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W/8-1:0]   wr_be_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_err_o
);

    logic [DATA_W-1:0] word_sel;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              in_range;
    logic              wr_hit;

    // Explicit compare per entry keeps the select in range even when DEPTH < 2**ADDR_W.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_i == ADDR_W'(i)) begin
                word_sel = mem_i[i];
            end
        end
    end

    assign in_range = int'(rd_addr_i) < DEPTH;

    // A clearing cycle always returns pre-clear contents, so it disables the bypass.
    assign wr_hit = (BYPASS != 0) && wr_en_i && !clr_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            if (!in_range) begin
                rd_data_d = '0;
            end else if (wr_hit) begin
                rd_data_d = DATA_W'(byte_merge(word_max_t'(word_sel),
                                               word_max_t'(wr_data_i),
                                               be_max_t'(wr_be_i)));
            end else begin
                rd_data_d = word_sel;
            end
        end
    end

    assign rd_err_o = rd_en_i && !in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en_i;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file with one byte-masked write port and two registered
// read ports; supports synchronous bulk clear and out-of-range access flagging.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = calc_addr_w(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W/8-1:0]   wr_be_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  rd0_en_i,
    input  logic [ADDR_W-1:0]     rd0_addr_i,
    input  logic                  rd1_en_i,
    input  logic [ADDR_W-1:0]     rd1_addr_i,
    output logic [DATA_W-1:0]     rd0_data_o,
    output logic                  rd0_valid_o,
    output logic [DATA_W-1:0]     rd1_data_o,
    output logic                  rd1_valid_o,
    output logic                  addr_err_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_in_range;
    logic              wr_err;
    logic              rd0_err;
    logic              rd1_err;
    logic              addr_err_d;
    logic              addr_err_q;

    assign wr_in_range = int'(wr_addr_i) < DEPTH;
    assign wr_err      = wr_en_i && !wr_in_range;

    // NOTE: mem_d takes a full default first so every path assigns it and no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr_i == ADDR_W'(i)) begin
                    mem_d[i] = DATA_W'(byte_merge(word_max_t'(mem_q[i]),
                                                  word_max_t'(wr_data_i),
                                                  be_max_t'(wr_be_i)));
                end
            end
        end
    end

    assign addr_err_d = wr_err || rd0_err || rd1_err;

    // NOTE: the storage array is reset too, since every entry must read 0 after reset.
    // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            addr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err_o = addr_err_q;

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd0 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .mem_i      (mem_q),
        .clr_i      (clr_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_be_i    (wr_be_i),
        .wr_data_i  (wr_data_i),
        .rd_en_i    (rd0_en_i),
        .rd_addr_i  (rd0_addr_i),
        .rd_data_o  (rd0_data_o),
        .rd_valid_o (rd0_valid_o),
        .rd_err_o   (rd0_err)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd1 (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .mem_i      (mem_q),
        .clr_i      (clr_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_be_i    (wr_be_i),
        .wr_data_i  (wr_data_i),
        .rd_en_i    (rd1_en_i),
        .rd_addr_i  (rd1_addr_i),
        .rd_data_o  (rd1_data_o),
        .rd_valid_o (rd1_valid_o),
        .rd_err_o   (rd1_err)
    );

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file: one write port, two independent read ports.
- Adds over the single-port 8x16 register file:
  - configurable width and depth;
  - simultaneous write and reads;
  - per-byte write enables;
  - read-during-write bypass;
  - synchronous bulk clear;
  - address-range error flagging.
- Serves as operand storage for the datapath blocks.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- DEPTH, 8, number of entries; need not be a power of two.
- ADDR_W, max(1, clog2(DEPTH)), address width (derived).
- BYPASS, 1: 1 = a read hitting the same-cycle write returns the new (merged) data; 0 = returns the old data.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear of all entries.
- WR_EN  in  1  write request.
- WR_ADDR  in  ADDR_W  write address.
- WR_BE  in  DATA_W/8  byte enables; bit i covers WR_DATA[8i+7:8i].
- WR_DATA  in  DATA_W  write data.
- RD0_EN / RD1_EN  in  1  read request, per port.
- RD0_ADDR / RD1_ADDR  in  ADDR_W  read address.
- RD0_DATA / RD1_DATA  out  DATA_W  registered read data.
- RD0_VALID / RD1_VALID  out  1  one-cycle pulse: RDx_DATA was updated.
- ADDR_ERR  out  1  one-cycle pulse: an out-of-range access occurred last cycle.

Behaviour:
- Reset (RST low, asynchronous):
  - all entries = 0;
  - RDx_DATA = 0, RDx_VALID = 0, ADDR_ERR = 0.
  - Reset mid-operation aborts any pending write; outputs clear immediately.
- Write (edge with WR_EN=1 and WR_ADDR < DEPTH):
  - for each i with WR_BE[i]=1, byte i of entry[WR_ADDR] takes byte i of WR_DATA;
  - other bytes are unchanged;
  - WR_BE = 0 is a legal no-op.
- Read latency is 1 cycle. At an edge with RDx_EN=1:
  - RDx_DATA is loaded, and RDx_VALID = 1 for the following cycle.
  - With RDx_EN=0: RDx_DATA holds its previous value and RDx_VALID = 0.
- Both read ports may use any addresses, including the same address, in the same cycle as each other and as a write.
- Read-during-write (RDx_ADDR == WR_ADDR, WR_EN=1, same edge):
  - BYPASS=1: RDx_DATA = old entry with the enabled bytes replaced by WR_DATA.
  - BYPASS=0: RDx_DATA = old entry.
- CLR=1 at an edge:
  - all entries become 0; CLR overrides any write in the same cycle;
  - reads in that cycle return the pre-clear contents, regardless of BYPASS;
  - RDx_VALID behaves normally.
- Out of range (address >= DEPTH; only possible when DEPTH is not a power of two):
  - write: ignored, storage unchanged;
  - read: RDx_DATA = 0, RDx_VALID = 1;
  - either case: ADDR_ERR = 1 for one cycle.
  - Addresses presented on ports whose EN=0 are never checked.
- ADDR_ERR is the OR of all flagged accesses in the cycle. No error is held or counted.
- Storage is fully synchronous: no combinational path from any input to any output.

Decomposition:
- Package reg_file_pkg:
  - default DATA_W/DEPTH constants;
  - function computing ADDR_W (minimum 1);
  - function computing the byte-merge of an old word, WR_DATA and WR_BE (shared by the write path and the bypass path).
- Sub-module reg_file_rd_port, instantiated twice. Contents:
  - address range check;
  - bypass compare and merge select;
  - RDx_DATA/RDx_VALID registers;
  - per-port error bit.

Test Plan (DATA_W=16, DEPTH=8 unless noted):
1. Reset, then RD0 addr 3 and RD1 addr 7 -> both DATA=0x0000, VALID pulse one cycle later; ADDR_ERR=0.
2. Write addr 2, 0xA5C3, BE=11; next cycle write addr 2, 0x1200, BE=10; then read addr 2 on RD0 -> 0x12C3.
3. Same edge: write addr 5, 0xBEEF, BE=11; RD0 addr 5; RD1 addr 5. Entry 5 initially 0x1111:
   - BYPASS=1 -> both ports 0xBEEF;
   - BYPASS=0 -> both ports 0x1111;
   - next read of entry 5 -> 0xBEEF in both builds.
4. Fill entries 0-7 with 0x0101*index; assert CLR with WR_EN to addr 4 (0xFFFF) and RD0 addr 6 ->
   - RD0=0x0606;
   - subsequent reads of all entries return 0x0000, including entry 4.
5. DEPTH=6:
   - write addr 7 -> ADDR_ERR pulses, entries unchanged;
   - RD1 addr 6 -> RD1_DATA=0x0000, RD1_VALID=1, ADDR_ERR=1;
   - RD0 addr 6 with RD0_EN=0 -> no error.
6. Assert RST low between two write edges of a burst -> outputs 0 asynchronously; after release, all entries read 0x0000.
